// File: rtl/clut_rle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clut_rle_pkg
// Description : Shared types and constants for the multi-mode CLUT
//               run-length decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package clut_rle_pkg;

    localparam int LINE_WIDTH_DEFAULT = 384;

    // Decode mode as sampled at reset / line start (3 is reserved -> passthrough)
    typedef enum logic [1:0] {
        PASSTHROUGH = 2'd0,
        RL7         = 2'd1,
        RL3         = 2'd2
    } rle_mode_e;

    // Decoder sequencing states
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        SECOND    = 3'd1,
        GET_COUNT = 3'd2,
        RUN       = 3'd3,
        RUN_EOL   = 3'd4
    } rle_state_e;

endpackage
`default_nettype wire

// File: rtl/line_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module      : line_pixel_counter
// Description : Counts pixels left in the current display line. Reloads the
//               line width on the last pixel and pulses eol one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module line_pixel_counter #(
    parameter int LINE_WIDTH = 384,
    parameter int COUNT_W    = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               count_en,
    input  logic               resync,
    output logic [COUNT_W-1:0] remaining,
    output logic               eol
);

    localparam logic [COUNT_W-1:0] c_LINE_WIDTH = COUNT_W'(LINE_WIDTH);
    localparam logic [COUNT_W-1:0] c_ONE        = COUNT_W'(1);

    logic [COUNT_W-1:0] r_remaining;
    logic               r_eol;

    // Down-count per pixel; resync restarts the line without counting
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_remaining <= c_LINE_WIDTH;
            r_eol       <= 1'b0;
        end else if (resync) begin
            r_remaining <= c_LINE_WIDTH;
            r_eol       <= 1'b0;
        end else if (count_en) begin
            if (r_remaining == c_ONE) begin
                r_remaining <= c_LINE_WIDTH;
                r_eol       <= 1'b1;
            end else begin
                r_remaining <= r_remaining - c_ONE;
                r_eol       <= 1'b0;
            end
        end else begin
            r_eol <= 1'b0;
        end
    end

    assign remaining = r_remaining;
    assign eol       = r_eol;

endmodule
`default_nettype wire

// File: rtl/clut_rle_multi.sv
`default_nettype none
// ============================================================================
// Module      : clut_rle_multi
// Description : Byte-stream to per-pixel CLUT index decoder supporting
//               passthrough, RL7 and RL3 run-length modes, with line-length
//               tracking, line resync and end-of-line run truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module clut_rle_multi
    import clut_rle_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT,
    parameter int COUNT_W    = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] mode,
    input  logic       line_start,
    input  logic [7:0] src_pixel,
    input  logic       src_write,
    output logic       src_strobe,
    output logic [7:0] dst_pixel,
    output logic       dst_write,
    input  logic       dst_strobe,
    output logic       eol,
    output logic       overrun
);

    rle_state_e         r_state;
    logic [1:0]         r_mode_q;
    logic               r_phase;
    logic [8:0]         r_run_cnt;
    logic [6:0]         r_hold_a;
    logic [2:0]         r_hold_b;
    logic               r_overrun;

    logic               w_rl7;
    logic               w_rl3;
    logic [7:0]         w_run_pix;
    logic               w_pix_xfer;
    logic               w_line_end;
    logic [COUNT_W-1:0] w_remaining;

    // Decoding is only active out of reset; reserved mode falls back to passthrough
    assign w_rl7      = reset_n && (r_mode_q == RL7);
    assign w_rl3      = reset_n && (r_mode_q == RL3);
    // RL3 hold_a is stored zero-extended, so one expression covers both modes
    assign w_run_pix  = (w_rl3 && r_phase) ? {5'b0, r_hold_b} : {1'b0, r_hold_a};
    assign w_pix_xfer = dst_write & dst_strobe;
    // Last pixel of the line is leaving this cycle (line_start overrides counting)
    assign w_line_end = w_pix_xfer && !line_start && (w_remaining == COUNT_W'(1));

    line_pixel_counter #(
        .LINE_WIDTH (LINE_WIDTH),
        .COUNT_W    (COUNT_W)
    ) u_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .count_en  (w_pix_xfer & ~line_start),
        .resync    (line_start),
        .remaining (w_remaining),
        .eol       (eol)
    );

    // Handshake and pixel selection; literals fall straight through from src
    always_comb begin
        dst_pixel  = src_pixel;
        dst_write  = src_write;
        src_strobe = dst_strobe;
        if (w_rl7 || w_rl3) begin
            case (r_state)
                FETCH: begin
                    if (src_pixel[7]) begin
                        dst_write  = 1'b0;
                        src_strobe = src_write;
                    end else if (w_rl7) begin
                        dst_pixel = {1'b0, src_pixel[6:0]};
                    end else begin
                        // First index of an RL3 pair; byte is held for SECOND
                        dst_pixel  = {5'b0, src_pixel[6:4]};
                        src_strobe = 1'b0;
                    end
                end
                SECOND: begin
                    dst_pixel  = {5'b0, r_hold_b};
                    dst_write  = 1'b1;
                    src_strobe = dst_strobe;
                end
                GET_COUNT: begin
                    dst_write  = 1'b0;
                    src_strobe = src_write;
                end
                RUN, RUN_EOL: begin
                    dst_pixel  = w_run_pix;
                    dst_write  = 1'b1;
                    src_strobe = 1'b0;
                end
                default: begin
                    dst_write  = 1'b0;
                    src_strobe = 1'b0;
                end
            endcase
        end
    end

    // Decoder sequencing: line_start aborts everything, runs end on count or eol
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= FETCH;
            r_phase   <= 1'b0;
            r_run_cnt <= 9'd0;
            r_mode_q  <= mode;
            r_overrun <= 1'b0;
            r_hold_a  <= 7'd0;
            r_hold_b  <= 3'd0;
        end else if (line_start) begin
            r_state   <= FETCH;
            r_phase   <= 1'b0;
            r_run_cnt <= 9'd0;
            r_mode_q  <= mode;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                FETCH: begin
                    if ((w_rl7 || w_rl3) && src_write && src_pixel[7]) begin
                        r_hold_a <= w_rl7 ? src_pixel[6:0] : {4'b0, src_pixel[6:4]};
                        r_hold_b <= src_pixel[2:0];
                        r_state  <= GET_COUNT;
                    end else if (w_rl3 && w_pix_xfer) begin
                        r_hold_b <= src_pixel[2:0];
                        r_state  <= SECOND;
                    end
                end
                SECOND: begin
                    if (w_pix_xfer) begin
                        r_state <= FETCH;
                    end
                end
                GET_COUNT: begin
                    if (src_write) begin
                        r_phase <= 1'b0;
                        if (src_pixel == 8'd0) begin
                            r_state <= RUN_EOL;
                        end else begin
                            r_run_cnt <= w_rl3 ? {src_pixel, 1'b0} : {1'b0, src_pixel};
                            r_state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_pix_xfer) begin
                        r_phase <= ~r_phase;
                        if (w_line_end && (r_run_cnt > 9'd1)) begin
                            r_overrun <= 1'b1;
                            r_run_cnt <= 9'd0;
                            r_state   <= FETCH;
                        end else if (r_run_cnt == 9'd1) begin
                            r_run_cnt <= 9'd0;
                            r_state   <= FETCH;
                        end else begin
                            r_run_cnt <= r_run_cnt - 9'd1;
                        end
                    end
                end
                RUN_EOL: begin
                    if (w_pix_xfer) begin
                        r_phase <= ~r_phase;
                        if (w_line_end) begin
                            r_state <= FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_clut_rle_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clut_rle_multi
// Description : Self-checking bench for clut_rle_multi. Bytes are expanded
//               into an expected pixel list (with eol/overrun flags) at token
//               level and compared against the DUT pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clut_rle_multi;
    import clut_rle_pkg::*;

    localparam int LW    = 384;
    localparam int BOUND = 20000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] mode;
    logic       line_start;
    logic [7:0] src_pixel;
    logic       src_write;
    logic       src_strobe;
    logic [7:0] dst_pixel;
    logic       dst_write;
    logic       dst_strobe;
    logic       eol;
    logic       overrun;

    typedef struct packed {
        logic [7:0] pix;
        logic       eol;
        logic       ovr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    int         xfer_cyc[$];
    int         total = 0;
    int         bad = 0;
    int         m_pos = 0;
    int         m_mode = 0;
    int         cyc = 0;
    int         byte_xfers = 0;
    int         pix_xfers = 0;
    bit         presenting = 1'b0;

    always #5 clk = ~clk;

    clut_rle_multi #(
        .LINE_WIDTH (LW),
        .COUNT_W    (11)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .line_start (line_start),
        .src_pixel  (src_pixel),
        .src_write  (src_write),
        .src_strobe (src_strobe),
        .dst_pixel  (dst_pixel),
        .dst_write  (dst_write),
        .dst_strobe (dst_strobe),
        .eol        (eol),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: one expected pixel, advancing the line position
    task automatic exp_pix(input logic [7:0] p, input bit ovr);
        exp_t e;
        e.pix = p;
        e.ovr = ovr;
        m_pos++;
        e.eol = (m_pos == LW);
        if (m_pos == LW) m_pos = 0;
        exp_q.push_back(e);
    endtask

    task automatic send_lit(input logic [7:0] b);
        src_q.push_back(b);
        if (m_mode == 1) begin
            exp_pix({1'b0, b[6:0]}, 1'b0);
        end else if (m_mode == 2) begin
            exp_pix({5'b0, b[6:4]}, 1'b0);
            exp_pix({5'b0, b[2:0]}, 1'b0);
        end else begin
            exp_pix(b, 1'b0);
        end
    endtask

    task automatic send_run(input logic [7:0] hdr, input logic [7:0] cnt);
        int n;
        int left;
        int k;
        logic [7:0] pa;
        logic [7:0] pb;
        src_q.push_back(hdr | 8'h80);
        src_q.push_back(cnt);
        left = LW - m_pos;
        if (cnt == 8'd0) n = left;
        else n = (m_mode == 2) ? 2 * int'(cnt) : int'(cnt);
        k  = (n < left) ? n : left;
        pa = (m_mode == 2) ? {5'b0, hdr[6:4]} : {1'b0, hdr[6:0]};
        pb = {5'b0, hdr[2:0]};
        for (int i = 0; i < k; i++)
            exp_pix((m_mode == 2 && (i % 2) == 1) ? pb : pa, (i == k - 1) && (n > k));
    endtask

    // One clock: drive at negedge, check combinational side, then registered flags
    task automatic step(input bit stall, input bit ls);
        exp_t e;
        bit px;
        bit by;
        logic [7:0] dummy;
        @(negedge clk);
        line_start = ls;
        dst_strobe = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!presenting && src_q.size() > 0 && (!stall || $urandom_range(0, 3) != 0))
            presenting = 1'b1;
        if (presenting) begin
            src_write = 1'b1;
            src_pixel = src_q[0];
        end else begin
            src_write = 1'b0;
            src_pixel = 8'($urandom);
        end
        #1;
        px = dst_write & dst_strobe;
        by = src_write & src_strobe;
        e  = '0;
        if (px) begin
            chk("pixel_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dst_pixel", 32'(dst_pixel), 32'(e.pix));
            end
            pix_xfers++;
            xfer_cyc.push_back(cyc);
        end
        if (by) begin
            dummy = src_q.pop_front();
            presenting = 1'b0;
            byte_xfers++;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("eol", 32'(eol), 32'(e.eol & ~ls));
        chk("overrun", 32'(overrun), 32'(e.ovr & ~ls));
    endtask

    task automatic drain(input bit stall);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || src_q.size() > 0) && n < BOUND) begin
            step(stall, 1'b0);
            n++;
        end
        chk("drain_in_time", 32'(n < BOUND), 32'd1);
        step(stall, 1'b0);
        step(stall, 1'b0);
    endtask

    task automatic new_line(input logic [1:0] md);
        mode = md;
        step(1'b0, 1'b1);
        m_pos  = 0;
        m_mode = (md == 2'd1 || md == 2'd2) ? int'(md) : 0;
    endtask

    task automatic wait_pixels(input int cnt);
        int start;
        int n;
        start = pix_xfers;
        n = 0;
        while (pix_xfers - start < cnt && n < 1000) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk("pixels_in_time", 32'(n < 1000), 32'd1);
    endtask

    initial begin
        logic [1:0] md;

        reset_n    = 1'b0;
        mode       = 2'd1;
        line_start = 1'b0;
        src_pixel  = 8'h00;
        src_write  = 1'b0;
        dst_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_eol", 32'(eol), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_remaining", 32'(dut.w_remaining), 32'(LW));
        chk("reset_state", 32'(dut.r_state), 32'(FETCH));
        chk("reset_mode_q", 32'(dut.r_mode_q), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        m_mode  = 1;
        m_pos   = 0;

        // RL7 literal, run of 3, literal: no gap after the run
        new_line(2'd1);
        xfer_cyc.delete();
        send_lit(8'h05);
        send_run(8'h85, 8'd3);
        send_lit(8'h07);
        drain(1'b0);
        chk("rl7_pixel_count", 32'(xfer_cyc.size()), 32'd5);
        if (xfer_cyc.size() == 5) begin
            chk("run_back_to_back", 32'(xfer_cyc[3] - xfer_cyc[1]), 32'd2);
            chk("no_idle_after_run", 32'(xfer_cyc[4] - xfer_cyc[3]), 32'd1);
        end

        // RL3 literal pair then a run of two pairs
        new_line(2'd2);
        byte_xfers = 0;
        send_lit(8'h35);
        send_run(8'hA1, 8'd2);
        drain(1'b0);
        chk("rl3_byte_xfers", 32'(byte_xfers), 32'd3);

        // Run-to-end-of-line after 380 literals
        new_line(2'd1);
        for (int i = 0; i < 380; i++) send_lit(8'($urandom_range(0, 127)));
        send_run(8'h92, 8'd0);
        drain(1'b0);
        chk("eol_reload", 32'(dut.w_remaining), 32'(LW));
        send_lit(8'h33);
        drain(1'b0);
        chk("remaining_after_lit", 32'(dut.w_remaining), 32'(LW - m_pos));

        // Run of 10 truncated with 3 pixels left on the line
        new_line(2'd1);
        for (int i = 0; i < 381; i++) send_lit(8'($urandom_range(0, 127)));
        send_run(8'h8A, 8'd10);
        send_lit(8'h44);
        drain(1'b0);
        chk("truncate_remaining", 32'(dut.w_remaining), 32'(LW - m_pos));

        // Random streams with random stalls in every mode
        for (int t = 0; t < 4; t++) begin
            md = 2'((t + 1) % 4);
            new_line(md);
            for (int i = 0; i < 30; i++) begin
                if (m_mode != 0 && $urandom_range(0, 2) == 0)
                    send_run(8'($urandom), 8'($urandom_range(0, 40)));
                else if (m_mode != 0)
                    send_lit(8'($urandom_range(0, 127)));
                else
                    send_lit(8'($urandom));
            end
            drain(1'b1);
            chk("random_remaining", 32'(dut.w_remaining), 32'(LW - m_pos));
        end

        // line_start in the middle of an RL7 run
        new_line(2'd1);
        send_run(8'h9C, 8'd60);
        wait_pixels(10);
        mode = 2'd2;
        step(1'b1, 1'b1);
        exp_q.delete();
        m_pos  = 0;
        m_mode = 2;
        chk("abort_remaining", 32'(dut.w_remaining), 32'(LW));
        chk("abort_state", 32'(dut.r_state), 32'(FETCH));
        send_lit(8'h35);
        send_run(8'hA1, 8'd3);
        drain(1'b1);

        // line_start in the middle of an RL3 run, on the odd phase
        send_run(8'hC5, 8'd40);
        wait_pixels(7);
        mode = 2'd1;
        step(1'b1, 1'b1);
        exp_q.delete();
        m_pos  = 0;
        m_mode = 1;
        send_lit(8'h22);
        drain(1'b1);

        // Reset while a run-to-eol is in progress
        new_line(2'd1);
        send_run(8'h81, 8'd0);
        wait_pixels(5);
        mode = 2'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset_n    = 1'b0;
            line_start = 1'b0;
            src_pixel  = 8'($urandom);
            src_write  = 1'($urandom_range(0, 1));
            dst_strobe = 1'($urandom_range(0, 1));
            #1;
            chk("rst_dst_pixel", 32'(dst_pixel), 32'(src_pixel));
            chk("rst_dst_write", 32'(dst_write), 32'(src_write));
            chk("rst_src_strobe", 32'(src_strobe), 32'(dst_strobe));
            @(posedge clk);
            #1;
            chk("rst_state", 32'(dut.r_state), 32'(FETCH));
            chk("rst_mode_q", 32'(dut.r_mode_q), 32'd2);
            chk("rst_remaining", 32'(dut.w_remaining), 32'(LW));
            chk("rst_eol", 32'(eol), 32'd0);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        src_write = 1'b0;
        exp_q.delete();
        src_q.delete();
        presenting = 1'b0;
        m_pos  = 0;
        m_mode = 2;
        send_lit(8'h35);
        send_run(8'hA1, 8'd2);
        drain(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
